// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, character length limits
// and the parity helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 8;

  // Map the LCR character length onto the supported 5..8 range.
  function automatic logic [3:0] clamp_bits(input logic [3:0] n);
    logic [3:0] r;
    if (n < 4'(MIN_DATA_BITS)) begin
      r = 4'(MIN_DATA_BITS);
    end else if (n > 4'(MAX_DATA_BITS)) begin
      r = 4'(MAX_DATA_BITS);
    end else begin
      r = n;
    end
    return r;
  endfunction

  // Expected parity bit over the low nbits of data (even: ^data, odd: ~^data).
  function automatic logic parity_calc(input logic [7:0] data, input logic [3:0] nbits,
                                       input logic even);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < int'(nbits)) ? data[i] : 1'b0;
    end
    return even ? (^m) : (~^m);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-FIFO bus: one character per rx_valid pulse with its status.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       framing_err;
  logic       break_det;
  logic       rx_busy;

  modport master (output rx_data, rx_valid, parity_err, framing_err, break_det, rx_busy);
  modport slave  (input  rx_data, rx_valid, parity_err, framing_err, break_det, rx_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// rxd input conditioning: 2-flop synchroniser, plus (with
// UART_RX_MAJORITY_VOTE_EN defined) a 2-of-3 vote over the last three tick samples.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
`ifdef UART_RX_MAJORITY_VOTE_EN
  input  logic tick,
`endif
  output logic rxd_s,
  output logic bit_val
);

  logic [1:0] sync_r;

  // Two-flop synchroniser, reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rxd};
    end
  end

  assign rxd_s = sync_r[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_r;

  // Hold the samples from the two previous ticks (mid-2, mid-1 at decision time).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r <= 2'b11;
    end else if (tick) begin
      hist_r <= {hist_r[0], rxd_s};
    end else begin
      hist_r <= hist_r;
    end
  end

  assign bit_val = (hist_r[1] & hist_r[0]) | (hist_r[1] & rxd_s) | (hist_r[0] & rxd_s);
`else
  assign bit_val = rxd_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// 16550-style serial receiver. Oversampled by OVERSAMPLE ticks per bit;
// optional majority-vote sampling via UART_RX_MAJORITY_VOTE_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       tick,
  input  logic [3:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_even,
  input  logic [1:0] stop_bits,
  uart_rx_if.master  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_END   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] T_ZERO    = TW'(0);

  rx_state_t     state_r, state_n;
  logic [TW-1:0] tcnt_r, tcnt_n;
  logic [3:0]    bcnt_r, bcnt_n;
  logic [7:0]    shreg_r, shreg_n;
  logic          par_r, par_n;
  logic [7:0]    data_r, data_n;
  logic          valid_r, valid_n;
  logic          perr_r, perr_n;
  logic          ferr_r, ferr_n;
  logic          brk_r, brk_n;
  logic          busy_r;
  logic          rxd_s, bit_val_s;
  logic [3:0]    nb_s;

  // Only the first stop bit is checked, so the stop-bit count is not consumed here.
  logic unused_cfg_s;
  assign unused_cfg_s = ^stop_bits;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rxd     (rxd),
`ifdef UART_RX_MAJORITY_VOTE_EN
    .tick    (tick),
`endif
    .rxd_s   (rxd_s),
    .bit_val (bit_val_s)
  );

  assign nb_s = clamp_bits(data_bits);

  // Next-state, counter and output-register logic; everything advances only on tick.
  always_comb begin
    state_n = state_r;
    tcnt_n  = tcnt_r;
    bcnt_n  = bcnt_r;
    shreg_n = shreg_r;
    par_n   = par_r;
    data_n  = data_r;
    valid_n = 1'b0;
    perr_n  = 1'b0;
    ferr_n  = 1'b0;
    brk_n   = 1'b0;
    if (tick) begin
      tcnt_n = tcnt_r + T_ONE;
      case (state_r)
        IDLE: begin
          if (!rxd_s) begin
            tcnt_n  = T_ZERO;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
        START: begin
          if (tcnt_r == MID_START) begin
            if (bit_val_s) begin
              state_n = IDLE;
            end else begin
              tcnt_n  = T_ZERO;
              bcnt_n  = 4'd0;
              shreg_n = 8'h00;
              state_n = DATA;
            end
          end else begin
            state_n = START;
          end
        end
        DATA: begin
          if (tcnt_r == BIT_END) begin
            if (bcnt_r < 4'd8) begin
              shreg_n[bcnt_r[2:0]] = bit_val_s;
            end else begin
              shreg_n = shreg_r;
            end
            bcnt_n = bcnt_r + 4'd1;
            // >= rather than == so a mid-frame length change still terminates the frame.
            if (bcnt_r >= nb_s - 4'd1) begin
              state_n = parity_en ? PARITY : STOP;
            end else begin
              state_n = DATA;
            end
          end else begin
            state_n = DATA;
          end
        end
        PARITY: begin
          if (tcnt_r == BIT_END) begin
            par_n   = bit_val_s;
            state_n = STOP;
          end else begin
            state_n = PARITY;
          end
        end
        STOP: begin
          if (tcnt_r == BIT_END) begin
            data_n  = shreg_r;
            valid_n = 1'b1;
            ferr_n  = ~bit_val_s;
            perr_n  = parity_en & (par_r ^ parity_calc(shreg_r, nb_s, parity_even));
            brk_n   = ~bit_val_s & (shreg_r == 8'h00) & (~parity_en | ~par_r);
            state_n = bit_val_s ? IDLE : WAIT_HIGH;
          end else begin
            state_n = STOP;
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) begin
            state_n = IDLE;
          end else begin
            state_n = WAIT_HIGH;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      tcnt_r  <= T_ZERO;
      bcnt_r  <= 4'd0;
      shreg_r <= 8'h00;
      par_r   <= 1'b0;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      brk_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      tcnt_r  <= tcnt_n;
      bcnt_r  <= bcnt_n;
      shreg_r <= shreg_n;
      par_r   <= par_n;
      data_r  <= data_n;
      valid_r <= valid_n;
      perr_r  <= perr_n;
      ferr_r  <= ferr_n;
      brk_r   <= brk_n;
      busy_r  <= (state_n != IDLE);
    end
  end

  assign bus.rx_data     = data_r;
  assign bus.rx_valid    = valid_r;
  assign bus.parity_err  = perr_r;
  assign bus.framing_err = ferr_r;
  assign bus.break_det   = brk_r;
  assign bus.rx_busy     = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frame
// batches compared against a bit-level reference model.
module tb_uart_rx;

  localparam int OS     = 16;
  localparam int TP     = 2;        // clk cycles per tick
  localparam int BITCLK = OS * TP;  // clk cycles per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] data_bits = 4'd8;
  logic       parity_en = 1'b0;
  logic       parity_even = 1'b0;
  logic [1:0] stop_bits = 2'd1;

  int checks = 0;
  int errors = 0;
  int leak = 0;
  int tdiv = 0;
  logic [10:0] q[$];  // {break, framing, parity, data} per received frame

  uart_rx_if bus();

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .tick        (tick),
    .data_bits   (data_bits),
    .parity_en   (parity_en),
    .parity_even (parity_even),
    .stop_bits   (stop_bits),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tdiv <= (tdiv + 1) % TP;
    tick <= (tdiv == 0);
  end

  always @(negedge clk) begin
    if (bus.rx_valid) q.push_back({bus.break_det, bus.framing_err, bus.parity_err, bus.rx_data});
    else if (bus.parity_err || bus.framing_err || bus.break_det) leak++;
  end

  function automatic int eff_bits(input int raw);
    return (raw < 5) ? 5 : ((raw > 8) ? 8 : raw);
  endfunction

  function automatic logic ref_parity(input logic [7:0] d, input int nb, input logic even);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    return even ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  function automatic logic [10:0] model(input logic [7:0] d, input int raw_bits, input logic pen,
                                        input logic peven, input logic flip, input logic stop_val);
    int nb = eff_bits(raw_bits);
    logic [7:0] rec = 8'h00;
    logic sent_par, perr, ferr, brk;
    for (int i = 0; i < nb; i++) rec[i] = d[i];
    sent_par = ref_parity(d, nb, peven) ^ flip;
    perr = pen && (sent_par != ref_parity(rec, nb, peven));
    ferr = !stop_val;
    brk  = !stop_val && (rec == 8'h00) && (!pen || !sent_par);
    return {brk, ferr, perr, rec};
  endfunction

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int raw_bits, input logic pen, input logic peven,
                            input logic flip, input logic stop_val, input int nstop);
    int nb = eff_bits(raw_bits);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pen) drive_bit(ref_parity(d, nb, peven) ^ flip);
    drive_bit(stop_val);
    if (nstop == 2) drive_bit(1'b1);
    rxd = 1'b1;
  endtask

  task automatic set_cfg(input int db, input logic pen, input logic pev, input int sb);
    data_bits = 4'(db); parity_en = pen; parity_even = pev; stop_bits = 2'(sb);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.rx_valid); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", bus.rx_data); end
    checks++; if ({bus.parity_err, bus.framing_err, bus.break_det} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {bus.parity_err, bus.framing_err, bus.break_det}); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.rx_busy); end
    rst = 1'b0;
    drive_bit(1'b1);
  endtask

  task automatic test_8n1();
    logic [10:0] e;
    q.delete(); set_cfg(8, 1'b0, 1'b0, 1);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drive_bit(1'b1); drive_bit(1'b1);
    e = model(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (q.size() !== 1) begin errors++; $display("FAIL 8n1_count: got %0d exp 1", q.size()); end
    else begin checks++; if (q[0] !== e) begin errors++; $display("FAIL 8n1_frame: got %h exp %h", q[0], e); end end
  endtask

  task automatic test_parity();
    logic [10:0] e0, e1;
    q.delete(); set_cfg(7, 1'b1, 1'b1, 1);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    drive_bit(1'b1);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    drive_bit(1'b1); drive_bit(1'b1);
    e0 = model(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1);
    e1 = model(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (q.size() !== 2) begin errors++; $display("FAIL 7e1_count: got %0d exp 2", q.size()); end
    else begin
      checks++; if (q[0] !== e0) begin errors++; $display("FAIL 7e1_good: got %h exp %h", q[0], e0); end
      checks++; if (q[1] !== e1) begin errors++; $display("FAIL 7e1_flipped: got %h exp %h", q[1], e1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e0, e1;
    q.delete(); set_cfg(5, 1'b1, 1'b0, 2);
    send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    send_frame(8'h0A, 5, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    drive_bit(1'b1); drive_bit(1'b1);
    e0 = model(8'h1F, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    e1 = model(8'h0A, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d exp 2", q.size()); end
    else begin
      checks++; if (q[0] !== e0) begin errors++; $display("FAIL b2b_first: got %h exp %h", q[0], e0); end
      checks++; if (q[1] !== e1) begin errors++; $display("FAIL b2b_second: got %h exp %h", q[1], e1); end
    end
  endtask

  task automatic test_framing();
    logic [10:0] e0, e1;
    q.delete(); set_cfg(8, 1'b0, 1'b0, 1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive_bit(1'b1); drive_bit(1'b1);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drive_bit(1'b1); drive_bit(1'b1);
    e0 = model(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    e1 = model(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (q.size() !== 2) begin errors++; $display("FAIL framing_count: got %0d exp 2", q.size()); end
    else begin
      checks++; if (q[0] !== e0) begin errors++; $display("FAIL framing_bad: got %h exp %h", q[0], e0); end
      checks++; if (q[1] !== e1) begin errors++; $display("FAIL framing_recover: got %h exp %h", q[1], e1); end
    end
  endtask

  task automatic test_break();
    logic [10:0] e;
    q.delete(); set_cfg(8, 1'b0, 1'b0, 1);
    rxd = 1'b0;
    repeat (30 * BITCLK) @(negedge clk);
    e = model(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (q.size() !== 1) begin errors++; $display("FAIL break_count: got %0d exp 1", q.size()); end
    else begin checks++; if (q[0] !== e) begin errors++; $display("FAIL break_frame: got %h exp %h", q[0], e); end end
    checks++; if (bus.rx_busy !== 1'b1) begin errors++; $display("FAIL break_busy_low: got %b exp 1", bus.rx_busy); end
    drive_bit(1'b1); drive_bit(1'b1);
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL break_busy_high: got %b exp 0", bus.rx_busy); end
    checks++; if (q.size() !== 1) begin errors++; $display("FAIL break_after_count: got %0d exp 1", q.size()); end
  endtask

  task automatic test_glitch();
    q.delete();
    rxd = 1'b0;
    repeat (4 * TP) @(negedge clk);
    rxd = 1'b1;
    drive_bit(1'b1); drive_bit(1'b1);
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL glitch_count: got %0d exp 0", q.size()); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b exp 0", bus.rx_busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] e;
    q.delete(); set_cfg(8, 1'b0, 1'b0, 1);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
    rxd = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b exp 0", bus.rx_busy); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h exp 00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b exp 0", bus.rx_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_bit(1'b1); drive_bit(1'b1);
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL midrst_partial: got %0d exp 0", q.size()); end
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drive_bit(1'b1); drive_bit(1'b1);
    e = model(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (q.size() !== 1) begin errors++; $display("FAIL midrst_next_count: got %0d exp 1", q.size()); end
    else begin checks++; if (q[0] !== e) begin errors++; $display("FAIL midrst_next_frame: got %h exp %h", q[0], e); end end
  endtask

  task automatic test_random();
    for (int b = 0; b < 4; b++) begin
      logic [10:0] exp_q[$];
      int db, sb;
      logic pen, pev;
      db  = int'($urandom_range(3, 10));
      pen = 1'($urandom_range(0, 1));
      pev = 1'($urandom_range(0, 1));
      sb  = int'($urandom_range(1, 2));
      q.delete(); set_cfg(db, pen, pev, sb);
      drive_bit(1'b1);
      for (int f = 0; f < 5; f++) begin
        logic [7:0] d;
        logic flip;
        d = 8'($urandom);
        flip = ($urandom_range(0, 3) == 0);
        send_frame(d, db, pen, pev, flip, 1'b1, sb);
        exp_q.push_back(model(d, db, pen, pev, flip, 1'b1));
        if ($urandom_range(0, 1) == 1) drive_bit(1'b1);
      end
      drive_bit(1'b1); drive_bit(1'b1);
      checks++; if (q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: batch %0d got %0d exp %0d", b, q.size(), exp_q.size()); end
      else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_frame: batch %0d idx %0d cfg db=%0d p=%b e=%b got %h exp %h", b, i, db, pen, pev, q[i], exp_q[i]); end
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_framing();
    test_break();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    checks++; if (leak !== 0) begin errors++; $display("FAIL flag_leak: got %0d exp 0", leak); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
